// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bus bundle: IMEM request/response channel, redirect inputs
// and the IF->ID presentation handshake. The master side is the fetch stage.
interface if_prefetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            IMEM_req;
    logic [XLEN-1:0] IMEM_addr;
    logic            IMEM_gnt;
    logic            IMEM_rvalid;
    logic [XLEN-1:0] IMEM_rdata;
    logic            EX_PC_Branch;
    logic [XLEN-1:0] EX_PC_Branch_dest;
    logic            ID_Jump;
    logic [XLEN-1:0] ID_PC_dest;
    logic            IF_Stall;
    logic            IF_valid;
    logic [XLEN-1:0] IF_PC;
    logic [XLEN-1:0] IF_Instruction;

    modport master (
        output IMEM_req, IMEM_addr, IF_valid, IF_PC, IF_Instruction,
        input  IMEM_gnt, IMEM_rvalid, IMEM_rdata,
        input  EX_PC_Branch, EX_PC_Branch_dest, ID_Jump, ID_PC_dest, IF_Stall
    );

    modport slave (
        input  IMEM_req, IMEM_addr, IF_valid, IF_PC, IF_Instruction,
        output IMEM_gnt, IMEM_rvalid, IMEM_rdata,
        output EX_PC_Branch, EX_PC_Branch_dest, ID_Jump, ID_PC_dest, IF_Stall
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a credit-limited prefetch FIFO between an
// in-order, variable-latency IMEM and the ID stage. Redirects flush the
// queue and mark every still-outstanding response for discard.
module if_prefetch_queue #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                Clk,
    input  logic                Reset,
    if_prefetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;

    // Prefetch storage and issued-PC tag queue (no reset needed: guarded by counts)
    logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] tag_mem   [FIFO_DEPTH];

    // Per-cycle control
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            credit_ok;
    logic            req;
    logic            issue;
    logic            rsp;
    logic            drop;
    logic            push;
    logic            pop;

    // Decode redirect, credit and handshake events for this cycle
    always_comb begin
        redirect         = bus.EX_PC_Branch | bus.ID_Jump;
        // EX branch is older than the ID jump, so it takes priority
        redirect_pc      = bus.EX_PC_Branch ? bus.EX_PC_Branch_dest : bus.ID_PC_dest;
        redirect_pc[1:0] = 2'b00;
        // Each slot is reserved at issue time so the FIFO can never overflow
        credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
        req       = !Reset && !redirect && credit_ok;
        issue     = req && bus.IMEM_gnt;
        // A response with nothing outstanding predates a reset and is ignored
        rsp       = bus.IMEM_rvalid && (outstanding_q != '0);
        drop      = rsp && (discard_q != '0);
        push      = rsp && !drop && !redirect;
        pop       = (count_q != '0) && !bus.IF_Stall && !redirect;
    end

    // Next-state for PC, counters and queue pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
        tag_wr_d      = tag_wr_q + PW'(issue);
        tag_rd_d      = tag_rd_q + PW'(rsp);
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // Everything still in flight after this cycle belongs to the old path
            discard_d  = outstanding_q - CW'(rsp);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            discard_d = discard_q - CW'(drop);
            count_d   = count_q + CW'(push) - CW'(pop);
            wr_ptr_d  = wr_ptr_q + PW'(push);
            rd_ptr_d  = rd_ptr_q + PW'(pop);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
        end
    end

    // Record issued PCs and capture accepted responses with their PC tag
    always_ff @(posedge Clk) begin
        if (issue) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.IMEM_rdata;
            pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
        end
    end

    assign bus.IMEM_req       = req;
    assign bus.IMEM_addr      = fetch_pc_q;
    assign bus.IF_valid       = (count_q != '0);
    assign bus.IF_PC          = (count_q != '0) ? pc_mem[rd_ptr_q] : '0;
    assign bus.IF_Instruction = (count_q != '0) ? instr_mem[rd_ptr_q] : NOP_INSTR;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: an in-order fixed-latency IMEM model
// returns ~addr as the instruction; issued addresses and ID-accepted
// {PC, instruction} pairs are checked against hand-tracked expectations.
module tb_if_prefetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    if_prefetch_queue_if #(.XLEN(32)) bus ();

    if_prefetch_queue #(
        .XLEN      (32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          n_pop = 0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive IMEM response, observe issue/accept, advance to next negedge
    task automatic cycle();
        logic redir;
        if (pend_addr.size() != 0 && pend_due[0] == cyc) begin
            bus.IMEM_rvalid = 1'b1;
            bus.IMEM_rdata  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.IMEM_rvalid = 1'b0;
            bus.IMEM_rdata  = 32'h0;
        end
        #1;
        redir = bus.EX_PC_Branch | bus.ID_Jump;
        if (!rst && bus.IMEM_req && bus.IMEM_gnt) begin
            check_val("issue_addr", bus.IMEM_addr, exp_fetch);
            pend_addr.push_back(bus.IMEM_addr);
            pend_due.push_back(cyc + lat);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (!rst && !redir && bus.IF_valid && !bus.IF_Stall) begin
            $display("ID accept cyc=%0d pc=%h instr=%h", cyc, bus.IF_PC, bus.IF_Instruction);
            check_val("if_pc", bus.IF_PC, exp_pc);
            check_val("if_instr", bus.IF_Instruction, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst                   = 1'b1;
        bus.IMEM_gnt          = 1'b0;
        bus.IMEM_rvalid       = 1'b0;
        bus.IMEM_rdata        = 32'h0;
        bus.EX_PC_Branch      = 1'b0;
        bus.EX_PC_Branch_dest = 32'h0;
        bus.ID_Jump           = 1'b0;
        bus.ID_PC_dest        = 32'h0;
        bus.IF_Stall          = 1'b0;
        exp_fetch             = 32'h0;
        exp_pc                = 32'h0;
        @(negedge clk);
        cycle();
        cycle();

        // Reset state
        #1;
        check_val("rst_req", {31'b0, bus.IMEM_req}, 32'h0);
        check_val("rst_addr", bus.IMEM_addr, 32'h0);
        check_val("rst_valid", {31'b0, bus.IF_valid}, 32'h0);
        check_val("rst_pc", bus.IF_PC, 32'h0);
        check_val("rst_instr", bus.IF_Instruction, NOP);

        // Streaming, 1-cycle IMEM: valid every cycle once filled
        rst          = 1'b0;
        bus.IMEM_gnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i >= 2) check_val("stream_valid", {31'b0, bus.IF_valid}, 32'h1);
            cycle();
        end

        // Stall: output frozen, credit stops issue once 4 are held
        bus.IF_Stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_val("stall_valid", {31'b0, bus.IF_valid}, 32'h1);
            check_val("stall_pc", bus.IF_PC, exp_pc);
            cycle();
        end
        #1;
        check_val("stall_credit_req", {31'b0, bus.IMEM_req}, 32'h0);
        bus.IF_Stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val("resume_valid", {31'b0, bus.IF_valid}, 32'h1);
            cycle();
        end

        // Grant withheld: request held with a stable address
        bus.IMEM_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("nognt_req", {31'b0, bus.IMEM_req}, 32'h1);
            check_val("nognt_addr", bus.IMEM_addr, exp_fetch);
            cycle();
        end
        #1;
        check_val("nognt_drained", {31'b0, bus.IF_valid}, 32'h0);
        bus.IMEM_gnt = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Simultaneous EX branch and ID jump: EX wins
        bus.EX_PC_Branch      = 1'b1;
        bus.EX_PC_Branch_dest = 32'h0000_0100;
        bus.ID_Jump           = 1'b1;
        bus.ID_PC_dest        = 32'h0000_0300;
        exp_fetch             = 32'h0000_0100;
        exp_pc                = 32'h0000_0100;
        #1;
        check_val("dual_redir_req", {31'b0, bus.IMEM_req}, 32'h0);
        cycle();
        bus.EX_PC_Branch = 1'b0;
        bus.ID_Jump      = 1'b0;
        #1;
        check_val("dual_flush_valid", {31'b0, bus.IF_valid}, 32'h0);
        for (int i = 0; i < 6; i++) cycle();

        // Unaligned jump target has its low bits cleared
        bus.ID_Jump    = 1'b1;
        bus.ID_PC_dest = 32'h0000_0302;
        exp_fetch      = 32'h0000_0300;
        exp_pc         = 32'h0000_0300;
        cycle();
        bus.ID_Jump = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // 3-cycle IMEM, branch with 3 fetches in flight
        lat = 3;
        for (int i = 0; i < 20 && pend_addr.size() != 3; i++) cycle();
        check_val("inflight3", 32'(pend_addr.size()), 32'd3);
        bus.EX_PC_Branch      = 1'b1;
        bus.EX_PC_Branch_dest = 32'h0000_0200;
        exp_fetch             = 32'h0000_0200;
        exp_pc                = 32'h0000_0200;
        #1;
        check_val("br_redir_req", {31'b0, bus.IMEM_req}, 32'h0);
        cycle();
        bus.EX_PC_Branch = 1'b0;
        #1;
        check_val("br_flush_valid", {31'b0, bus.IF_valid}, 32'h0);
        for (int i = 0; i < 12 && !bus.IF_valid; i++) cycle();
        check_val("br_wait_valid", {31'b0, bus.IF_valid}, 32'h1);
        check_val("br_first_pc", bus.IF_PC, 32'h0000_0200);
        for (int i = 0; i < 6; i++) cycle();

        // Reset with requests in flight and a non-empty queue
        bus.IF_Stall = 1'b1;
        for (int i = 0; i < 20 && !(pend_addr.size() == 2 && bus.IF_valid); i++) cycle();
        check_val("pre_rst_inflight", 32'(pend_addr.size()), 32'd2);
        check_val("pre_rst_valid", {31'b0, bus.IF_valid}, 32'h1);
        rst = 1'b1;
        cycle();
        rst          = 1'b0;
        bus.IMEM_gnt = 1'b0;
        bus.IF_Stall = 1'b0;
        exp_fetch    = 32'h0;
        exp_pc       = 32'h0;
        #1;
        check_val("mrst_valid", {31'b0, bus.IF_valid}, 32'h0);
        check_val("mrst_pc", bus.IF_PC, 32'h0);
        check_val("mrst_instr", bus.IF_Instruction, NOP);
        check_val("mrst_addr", bus.IMEM_addr, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            #1;
            check_val("late_rsp_ignored", {31'b0, bus.IF_valid}, 32'h0);
        end
        bus.IMEM_gnt = 1'b1;
        n_pop        = 0;
        for (int i = 0; i < 8; i++) cycle();
        check_val("refetch_pops", {31'b0, (n_pop != 0)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
